int_pipe_wakeup_scheduler: RTL and testbench

//  Sequencing controller between the integer issue queue and the 3 integer execution pipes.
//  - Pipes: 0 = ALU+BR, 1 = ALU+IMUL, 2 = ALU+IDIV.
//  - Tracks per-pipe writeback-slot reservations and the iterative divider state.
//  - Drives per-pipe ex_busy/long_busy back-pressure into the issue queue.
//  - Drives the common tag bus (ctb) wakeups at the exact cycle each issued op's result is due.

---
 rtl/int_pipe_wakeup_scheduler.sv | 115 +++++++++++
 tb/tb_int_pipe_wakeup_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_pipe_wakeup_scheduler.sv
// int_pipe_wakeup_scheduler: per-pipe writeback-slot reservations, divider FSM, busy back-pressure and ctb wakeups.
module int_pipe_wakeup_scheduler #(
  parameter int NUM_PIPES = 3,
  parameter int PRF_IDX_W = 6,
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 16,
  parameter int RSV_DEPTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_PIPES-1:0]           issue_valid,
  input  logic [NUM_PIPES*2-1:0]         issue_fu,
  input  logic [NUM_PIPES-1:0]           issue_rd_valid,
  input  logic [NUM_PIPES*PRF_IDX_W-1:0] issue_rd_idx,
  output logic [NUM_PIPES-1:0]           ex_busy,
  output logic [NUM_PIPES-1:0]           long_busy,
  output logic [NUM_PIPES-1:0]           ctb_valid,
  output logic [NUM_PIPES*PRF_IDX_W-1:0] ctb_prf_idx,
  output logic                           div_busy,
  output logic                           protocol_err
);
  localparam int IW = $clog2(RSV_DEPTH);
  localparam int CW = $clog2(DIV_LAT);
  localparam int MUL_PIPE = 1;
  localparam int DIV_PIPE = 2;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  div_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [RSV_DEPTH-1:1] v_q [NUM_PIPES];
  logic [RSV_DEPTH-1:1] v_d [NUM_PIPES];
  logic [RSV_DEPTH-1:1] r_q [NUM_PIPES];
  logic [RSV_DEPTH-1:1] r_d [NUM_PIPES];
  logic [PRF_IDX_W-1:0] tag_q [NUM_PIPES][1:RSV_DEPTH-1];
  logic [PRF_IDX_W-1:0] tag_d [NUM_PIPES][1:RSV_DEPTH-1];
  logic [IW-1:0] lat [NUM_PIPES];
  logic [NUM_PIPES-1:0] bad, ok;
  logic err_q, err_d, lb0_q, div_start;
  assign div_busy = state_q != IDLE;
  assign protocol_err = err_q;
  always_comb begin
    ex_busy = '0;
    long_busy = '0;
    ctb_valid = '0;
    ctb_prf_idx = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      ex_busy[p] = v_q[p][2];
      ctb_valid[p] = v_q[p][1] & r_q[p][1];
      ctb_prf_idx[p*PRF_IDX_W +: PRF_IDX_W] = tag_q[p][1];
      long_busy[p] = p == MUL_PIPE ? v_q[p][MUL_LAT+1] :
                     p == DIV_PIPE ? div_busy | v_q[p][DIV_LAT+1] : lb0_q;
    end
  end
  // Shift first, then check and write the issue's slot in post-shift coordinates.
  always_comb begin
    bad = '0;
    ok = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      lat[p] = issue_fu[2*p +: 2] == 2'b10 ? IW'(MUL_LAT) :
               issue_fu[2*p +: 2] == 2'b11 ? IW'(DIV_LAT) : IW'(1);
      v_d[p] = {1'b0, v_q[p][RSV_DEPTH-1:2]};
      r_d[p] = {1'b0, r_q[p][RSV_DEPTH-1:2]};
      for (int k = 1; k < RSV_DEPTH-1; k++) tag_d[p][k] = tag_q[p][k+1];
      tag_d[p][RSV_DEPTH-1] = '0;
      bad[p] = issue_valid[p] & (v_q[p][2] | v_d[p][lat[p]] |
               (issue_fu[2*p +: 2] == 2'b10 && p != MUL_PIPE) |
               (issue_fu[2*p +: 2] == 2'b11 && (p != DIV_PIPE || div_busy)));
      ok[p] = issue_valid[p] & ~bad[p] & ~flush;
      if (ok[p]) begin
        v_d[p][lat[p]] = 1'b1;
        r_d[p][lat[p]] = issue_rd_valid[p];
        tag_d[p][lat[p]] = issue_rd_idx[p*PRF_IDX_W +: PRF_IDX_W];
      end
      if (flush) begin
        v_d[p] = '0;
        r_d[p] = '0;
      end
    end
    div_start = ok[DIV_PIPE] & (issue_fu[2*DIV_PIPE +: 2] == 2'b11);
    err_d = err_q | (|(bad & ~{NUM_PIPES{flush}}));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q <= '{default: '0};
      r_q <= '{default: '0};
      tag_q <= '{default: '{default: '0}};
      err_q <= 1'b0;
      lb0_q <= 1'b0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
      tag_q <= tag_d;
      err_q <= err_d;
      lb0_q <= ~flush;
    end
  end
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (div_start) begin
          state_q <= BUSY;
          cnt_q <= CW'(DIV_LAT-1);
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          state_q <= cnt_q == CW'(1) ? DONE : BUSY;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_pipe_wakeup_scheduler.sv
// tb_int_pipe_wakeup_scheduler: directed scenarios plus random traffic against an absolute-time slot-booking model.
module tb_int_pipe_wakeup_scheduler;
  localparam int ML = 3;
  localparam int DL = 16;
  localparam int MAXC = 8192;
  logic clock = 1'b0;
  logic reset, flush;
  logic [2:0] issue_valid, issue_rd_valid, ex_busy, long_busy, ctb_valid;
  logic [5:0] issue_fu;
  logic [17:0] issue_rd_idx, ctb_prf_idx;
  logic div_busy, protocol_err;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  // Model: a booking per pipe per absolute broadcast cycle.
  bit mv [3][MAXC];
  bit mr [3][MAXC];
  logic [5:0] mt [3][MAXC];
  int dstart = -1000;
  bit merr = 1'b0;
  bit mlb0 = 1'b0;

  int_pipe_wakeup_scheduler dut (
    .clock(clock), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_fu(issue_fu), .issue_rd_valid(issue_rd_valid), .issue_rd_idx(issue_rd_idx),
    .ex_busy(ex_busy), .long_busy(long_busy), .ctb_valid(ctb_valid),
    .ctb_prf_idx(ctb_prf_idx), .div_busy(div_busy), .protocol_err(protocol_err));

  always #5 clock = ~clock;

  function automatic int lat_of(logic [1:0] f);
    return f == 2'b10 ? ML : f == 2'b11 ? DL : 1;
  endfunction

  function automatic bit m_divb(int c);
    return c > dstart && c <= dstart + DL;
  endfunction

  task automatic issue(int p, logic [1:0] f, logic rv, logic [5:0] idx);
    issue_valid[p] = 1'b1;
    issue_fu[2*p +: 2] = f;
    issue_rd_valid[p] = rv;
    issue_rd_idx[6*p +: 6] = idx;
  endtask

  task automatic tick;
    int c = cyc;
    if (reset || flush) begin
      for (int p = 0; p < 3; p++)
        for (int k = c + 1; k < c + 40; k++) mv[p][k] = 1'b0;
      dstart = -1000;
      mlb0 = 1'b0;
      if (reset) merr = 1'b0;
    end else begin
      mlb0 = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (issue_valid[p]) begin
          logic [1:0] f = issue_fu[2*p +: 2];
          int l = lat_of(f);
          bit b = mv[p][c+1] || mv[p][c+l] || (f == 2'b10 && p != 1) ||
                  (f == 2'b11 && (p != 2 || m_divb(c)));
          if (b) merr = 1'b1;
          else begin
            mv[p][c+l] = 1'b1;
            mr[p][c+l] = issue_rd_valid[p];
            mt[p][c+l] = issue_rd_idx[6*p +: 6];
            if (f == 2'b11) dstart = c;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
    flush = 1'b0;
    issue_valid = '0;
    issue_fu = '0;
    issue_rd_valid = '0;
    issue_rd_idx = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (ctb_valid !== 3'b000) begin errors++; $display("FAIL reset_ctb_valid: got %b expected 000", ctb_valid); end
    checks++; if (ctb_prf_idx !== 18'h0) begin errors++; $display("FAIL reset_ctb_idx: got %h expected 0", ctb_prf_idx); end
    checks++; if (ex_busy !== 3'b000) begin errors++; $display("FAIL reset_ex_busy: got %b expected 000", ex_busy); end
    checks++; if (long_busy !== 3'b000) begin errors++; $display("FAIL reset_long_busy: got %b expected 000", long_busy); end
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_div_busy: got %b expected 0", div_busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", protocol_err); end
    tick();
    checks++; if (long_busy !== 3'b001) begin errors++; $display("FAIL idle_long_busy: got %b expected 001", long_busy); end
  endtask

  task automatic test_alu;
    do_reset();
    issue(0, 2'b00, 1'b1, 6'd5);
    checks++; if (ex_busy[0] !== 1'b0) begin errors++; $display("FAIL alu_ex_busy_t: got %b expected 0", ex_busy[0]); end
    tick();
    checks++; if (ctb_valid !== 3'b001) begin errors++; $display("FAIL alu_ctb_t1: got %b expected 001", ctb_valid); end
    checks++; if (ctb_prf_idx[5:0] !== 6'd5) begin errors++; $display("FAIL alu_tag_t1: got %0d expected 5", ctb_prf_idx[5:0]); end
    checks++; if (ex_busy[0] !== 1'b0) begin errors++; $display("FAIL alu_ex_busy_t1: got %b expected 0", ex_busy[0]); end
    tick();
    checks++; if (ctb_valid !== 3'b000) begin errors++; $display("FAIL alu_ctb_t2: got %b expected 000", ctb_valid); end
  endtask

  task automatic test_mul;
    do_reset();
    issue(1, 2'b10, 1'b1, 6'd9);
    tick();
    issue(1, 2'b00, 1'b1, 6'd20);
    tick();
    checks++; if (ex_busy[1] !== 1'b1) begin errors++; $display("FAIL mul_ex_busy_t2: got %b expected 1", ex_busy[1]); end
    checks++; if (ctb_valid[1] !== 1'b1 || ctb_prf_idx[11:6] !== 6'd20) begin errors++; $display("FAIL mul_alu_ctb_t2: got v=%b tag=%0d expected v=1 tag=20", ctb_valid[1], ctb_prf_idx[11:6]); end
    tick();
    checks++; if (ctb_valid[1] !== 1'b1 || ctb_prf_idx[11:6] !== 6'd9) begin errors++; $display("FAIL mul_ctb_t3: got v=%b tag=%0d expected v=1 tag=9", ctb_valid[1], ctb_prf_idx[11:6]); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL mul_err: got %b expected 0", protocol_err); end
  endtask

  task automatic test_div;
    do_reset();
    issue(2, 2'b11, 1'b1, 6'd12);
    tick();
    for (int k = 1; k <= 22; k++) begin
      checks++; if (div_busy !== (k <= DL)) begin errors++; $display("FAIL div_busy_t%0d: got %b expected %b", k, div_busy, k <= DL); end
      checks++; if (ctb_valid[2] !== (k == DL)) begin errors++; $display("FAIL div_ctb_t%0d: got %b expected %b", k, ctb_valid[2], k == DL); end
      if (k == DL) begin
        checks++; if (ctb_prf_idx[17:12] !== 6'd12) begin errors++; $display("FAIL div_tag: got %0d expected 12", ctb_prf_idx[17:12]); end
      end
      checks++; if (protocol_err !== (k >= 6)) begin errors++; $display("FAIL div_err_t%0d: got %b expected %b", k, protocol_err, k >= 6); end
      if (k == 5) issue(2, 2'b11, 1'b1, 6'd13);
      tick();
    end
  endtask

  task automatic test_div_flush;
    do_reset();
    issue(2, 2'b11, 1'b1, 6'd12);
    tick();
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL flush_div_busy: got %b expected 0", div_busy); end
    checks++; if (ex_busy !== 3'b000 || long_busy !== 3'b000) begin errors++; $display("FAIL flush_busy: got ex=%b long=%b expected 000 000", ex_busy, long_busy); end
    issue(2, 2'b11, 1'b1, 6'd14);
    tick();
    for (int k = 6; k <= 22; k++) begin
      checks++; if (div_busy !== (k <= 21)) begin errors++; $display("FAIL flush_div_busy_t%0d: got %b expected %b", k, div_busy, k <= 21); end
      checks++; if (ctb_valid[2] !== (k == 21)) begin errors++; $display("FAIL flush_ctb_t%0d: got %b expected %b", k, ctb_valid[2], k == 21); end
      if (k == 21) begin
        checks++; if (ctb_prf_idx[17:12] !== 6'd14) begin errors++; $display("FAIL flush_div_tag: got %0d expected 14", ctb_prf_idx[17:12]); end
      end
      tick();
    end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", protocol_err); end
  endtask

  task automatic test_wrong_pipe;
    do_reset();
    issue(0, 2'b10, 1'b1, 6'd7);
    tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL wrong_pipe_err: got %b expected 1", protocol_err); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (ctb_valid[0] !== 1'b0) begin errors++; $display("FAIL wrong_pipe_ctb_t%0d: got %b expected 0", k, ctb_valid[0]); end
      tick();
    end
    flush = 1'b1;
    tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_sticky_flush: got %b expected 1", protocol_err); end
    do_reset();
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL err_reset_clear: got %b expected 0", protocol_err); end
  endtask

  task automatic test_back_to_back;
    logic [17:0] prev;
    do_reset();
    issue(0, 2'b01, 1'b0, 6'd33);
    tick();
    checks++; if (ctb_valid[0] !== 1'b0 || ex_busy[0] !== 1'b0) begin errors++; $display("FAIL br_norv: got ctb=%b ex=%b expected 0 0", ctb_valid[0], ex_busy[0]); end
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        checks++; if (ctb_valid !== 3'b111 || ctb_prf_idx !== prev) begin errors++; $display("FAIL b2b_ctb_%0d: got v=%b idx=%h expected v=111 idx=%h", i, ctb_valid, ctb_prf_idx, prev); end
      end
      checks++; if (ex_busy !== 3'b000) begin errors++; $display("FAIL b2b_ex_busy_%0d: got %b expected 000", i, ex_busy); end
      for (int p = 0; p < 3; p++) begin
        logic [5:0] t = 6'(i * 3 + p);
        issue(p, 2'b00, 1'b1, t);
        prev[6*p +: 6] = t;
      end
      tick();
    end
    checks++; if (ctb_valid !== 3'b111 || ctb_prf_idx !== prev) begin errors++; $display("FAIL b2b_last: got v=%b idx=%h expected v=111 idx=%h", ctb_valid, ctb_prf_idx, prev); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", protocol_err); end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int c = cyc;
      logic [2:0] ev, eb, el;
      for (int p = 0; p < 3; p++) begin
        ev[p] = mv[p][c] & mr[p][c];
        eb[p] = mv[p][c+1];
      end
      el = {m_divb(c) | mv[2][c+DL], mv[1][c+ML], mlb0};
      checks++; if (ctb_valid !== ev) begin errors++; $display("FAIL rnd_ctb_valid c%0d: got %b expected %b", c, ctb_valid, ev); end
      checks++; if (ex_busy !== eb) begin errors++; $display("FAIL rnd_ex_busy c%0d: got %b expected %b", c, ex_busy, eb); end
      checks++; if (long_busy !== el) begin errors++; $display("FAIL rnd_long_busy c%0d: got %b expected %b", c, long_busy, el); end
      checks++; if (div_busy !== m_divb(c)) begin errors++; $display("FAIL rnd_div_busy c%0d: got %b expected %b", c, div_busy, m_divb(c)); end
      checks++; if (protocol_err !== merr) begin errors++; $display("FAIL rnd_err c%0d: got %b expected %b", c, protocol_err, merr); end
      for (int p = 0; p < 3; p++)
        if (ev[p]) begin
          checks++; if (ctb_prf_idx[6*p +: 6] !== mt[p][c]) begin errors++; $display("FAIL rnd_tag p%0d c%0d: got %0d expected %0d", p, c, ctb_prf_idx[6*p +: 6], mt[p][c]); end
        end
      reset = $urandom_range(0, 299) == 0;
      flush = $urandom_range(0, 39) == 0;
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 2) == 0) begin
          logic [1:0] f = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 9) != 0)
            f = p == 0 ? {1'b0, f[0]} : p == 1 ? (f == 2'b11 ? 2'b10 : f) : (f == 2'b10 ? 2'b11 : f);
          issue(p, f, 1'($urandom_range(0, 3) != 0), 6'($urandom));
        end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    issue_valid = '0;
    issue_fu = '0;
    issue_rd_valid = '0;
    issue_rd_idx = '0;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_div_flush();
    test_wrong_pipe();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
